// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage -- instruction-fetch stage and IF/ID pipeline register
//
// Holds the PC, issues one instruction-memory request at a time, captures the
// returned word into the IF/ID register and presents its opcode field to the
// control unit. A taken branch flushes the stage and redirects the PC; decode
// back-pressure (id_ready low) stalls it, with a one-entry pending buffer that
// absorbs the single word that can already be in flight.
//
// Optional feature: define IF_STAGE_PERF_EN to add the performance counters
// perf_fetch_cnt / perf_flush_cnt. With the macro undefined those ports and
// counters do not exist and all other behaviour is identical.
//
// Handshakes:
//   imem_req/imem_addr : request strobe, presented combinationally while the
//                        FSM is in FETCH and no redirect is active; at most
//                        one request is outstanding. imem_addr is always pc.
//   imem_valid/rdata   : one-cycle response strobe; only meaningful in WAIT,
//                        ignored in FETCH and HOLD.
//   if_id_valid/id_ready: the IF/ID contents move to decode on a rising edge
//                        where both are high (unless branch_taken flushes).
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   imem_req           fetch request strobe
//   imem_addr          fetch address (= pc)
//   imem_valid         response strobe
//   imem_rdata         instruction word
//   branch_taken       one-cycle redirect pulse (highest priority)
//   branch_target      redirect address, bits [1:0] forced to zero
//   id_ready           decode accepts IF/ID this cycle
//   if_id_valid        IF/ID holds a live instruction
//   if_id_instr        fetched instruction
//   if_id_pc_plus4     address of that instruction + 4
//   opcode             if_id_instr[31:26]
//   perf_fetch_cnt     (IF_STAGE_PERF_EN) IF/ID loads, incl. from pending
//   perf_flush_cnt     (IF_STAGE_PERF_EN) branch_taken pulses
// ---------------------------------------------------------------------------
module if_stage #(
   parameter int unsigned         PC_WIDTH = 32,
   parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
   input  logic                clk,
   input  logic                rst_n,
   output logic                imem_req,
   output logic [PC_WIDTH-1:0] imem_addr,
   input  logic                imem_valid,
   input  logic [31:0]         imem_rdata,
   input  logic                branch_taken,
   input  logic [PC_WIDTH-1:0] branch_target,
   input  logic                id_ready,
   output logic                if_id_valid,
   output logic [31:0]         if_id_instr,
   output logic [PC_WIDTH-1:0] if_id_pc_plus4,
   output logic [5:0]          opcode
`ifdef IF_STAGE_PERF_EN
   ,
   output logic [31:0]         perf_fetch_cnt,
   output logic [31:0]         perf_flush_cnt
`endif
);

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_WAIT  = 2'd1,
      S_HOLD  = 2'd2
   } state_t;

   state_t              state;
   logic [PC_WIDTH-1:0] pc;
   logic                drop;          // outstanding response must be discarded
   logic                pend_valid;
   logic [31:0]         pend_instr;
   logic [PC_WIDTH-1:0] pend_pc_plus4;

   logic [PC_WIDTH-1:0] pc_plus4;
   logic [PC_WIDTH-1:0] target_aligned;
   logic                transfer;
   logic                resp_live;
   logic                load_direct;
   logic                park;
   logic                load_pend;
   logic                unused_target_bits;

   // Modulo-2^PC_WIDTH increment; wraps naturally.
   assign pc_plus4       = pc + PC_WIDTH'(4);
   assign target_aligned = {branch_target[PC_WIDTH-1:2], 2'b00};
   assign unused_target_bits = ^branch_target[1:0];

   assign imem_req  = (state == S_FETCH) && !branch_taken;
   assign imem_addr = pc;

   // opcode comes from the IF/ID register only, so there is no combinational
   // path from imem_rdata to the control unit.
   assign opcode = if_id_instr[31:26];

   assign transfer = if_id_valid && id_ready;

   // A response that is to be kept: in WAIT, not marked stale, not flushed.
   assign resp_live   = (state == S_WAIT) && imem_valid && !drop && !branch_taken;
   // IF/ID can take the word now if empty or being drained this cycle.
   assign load_direct = resp_live && (!if_id_valid || id_ready);
   // Otherwise the word parks in the pending buffer.
   assign park        = resp_live && if_id_valid && !id_ready;
   // Pending word replaces the IF/ID contents as they move to decode.
   assign load_pend   = (state == S_HOLD) && id_ready && pend_valid && !branch_taken;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= S_FETCH;
         pc             <= RESET_PC;
         drop           <= 1'b0;
         pend_valid     <= 1'b0;
         pend_instr     <= '0;
         pend_pc_plus4  <= '0;
         if_id_valid    <= 1'b0;
         if_id_instr    <= '0;
         if_id_pc_plus4 <= '0;
      end else if (branch_taken) begin
         // Redirect wins over everything: flush IF/ID to a NOP, drop the
         // pending word and restart from the aligned target.
         if_id_valid <= 1'b0;
         if_id_instr <= '0;
         pc          <= target_aligned;
         pend_valid  <= 1'b0;
         if ((state == S_WAIT) && !imem_valid) begin
            // The stale response is still on its way; swallow it later.
            drop  <= 1'b1;
            state <= S_WAIT;
         end else begin
            drop  <= 1'b0;
            state <= S_FETCH;
         end
      end else begin
         // IF/ID register
         if (load_direct) begin
            if_id_valid    <= 1'b1;
            if_id_instr    <= imem_rdata;
            if_id_pc_plus4 <= pc_plus4;
         end else if (load_pend) begin
            if_id_valid    <= 1'b1;
            if_id_instr    <= pend_instr;
            if_id_pc_plus4 <= pend_pc_plus4;
         end else if (transfer) begin
            if_id_valid <= 1'b0;
         end

         // Fetch FSM
         case (state)
            S_FETCH: begin
               state <= S_WAIT;
            end
            S_WAIT: begin
               if (imem_valid) begin
                  if (drop) begin
                     drop  <= 1'b0;
                     state <= S_FETCH;
                  end else if (park) begin
                     pend_valid    <= 1'b1;
                     pend_instr    <= imem_rdata;
                     pend_pc_plus4 <= pc_plus4;
                     pc            <= pc_plus4;
                     state         <= S_HOLD;
                  end else begin
                     pc    <= pc_plus4;
                     state <= S_FETCH;
                  end
               end
            end
            S_HOLD: begin
               if (id_ready) begin
                  pend_valid <= 1'b0;
                  state      <= S_FETCH;
               end
            end
            default: begin
               state <= S_FETCH;
            end
         endcase
      end
   end

`ifdef IF_STAGE_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_fetch_cnt <= '0;
         perf_flush_cnt <= '0;
      end else begin
         if (branch_taken) begin
            perf_flush_cnt <= perf_flush_cnt + 32'd1;
         end
         if (load_direct || load_pend) begin
            perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
         end
      end
   end
`endif

endmodule
